dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sits in front of the single-port data memory (one combinational read port, one write port, 256 x 32-bit words, 15-bit word address).
- Shares the memory between two requesters: port 0 is the CPU load/store unit, port 1 is the DMA/debug loader.
- After reset, a built-in sequencer first fills every word with its own index (ram[i] = i), then hands the memory to round-robin arbitration.

Parameters:
- ADDR_W, 15, address width of the requester and memory ports.
- DATA_W, 32, data width.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.
- INIT_EN, 1, 1 = run the post-reset fill sequence; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, ports 0/1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational same-cycle grant; the access completes at the clock edge.
- rvalid0 / rvalid1  out  1  one-cycle pulse, the cycle after a granted read.
- rdata0 / rdata1  out  DATA_W  registered read data, valid while rvalid is high.
- err0 / err1  out  1  one-cycle pulse, the cycle after a granted out-of-range access.
- init_done  out  1  high once the fill is complete (stays high until reset).
- mem_we  out  1  write enable to the data memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational read data from the memory.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state = INIT (RUN if INIT_EN = 0), init_cnt = 0, rr_ptr = 0 (port 0 has priority first), init_done = 0.
- Also cleared by reset: rvalid0/1 = 0, err0/1 = 0, rdata0/1 = 0.
- Combinational outputs under reset: gnt0/1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- FSM states: INIT and RUN only.
- INIT state:
  - Drives mem_we = 1, mem_addr = init_cnt, mem_wdata = init_cnt zero-extended.
  - init_cnt increments every cycle.
  - After the cycle writing DEPTH-1, moves to RUN and sets init_done = 1. The fill takes exactly DEPTH cycles.
  - gnt0/1 stay 0 throughout; requesters hold req until granted.
- RUN state:
  - Only req0: gnt0 = 1. Only req1: gnt1 = 1.
  - Both requesting: grant the port selected by rr_ptr.
  - After any grant, rr_ptr points to the other port. With no grant, rr_ptr holds.
  - The granted port's addr/we/wdata drive mem_addr/mem_we/mem_wdata.
  - No grant: mem_we = 0 and mem_addr/mem_wdata hold their previous values (no toggling).
- Reads: granted with we = 0. On the next cycle rvalid of that port = 1 and rdata = mem_rdata as sampled at the grant edge.
- Writes: granted with we = 1. The memory is written at the grant edge; there is no rvalid.
- rdata holding: holds its last value when rvalid = 0.
- Out of range (addr >= DEPTH):
  - mem_we is forced to 0 and the memory is not modified.
  - A read returns rdata = 0 with rvalid = 1.
  - err of that port pulses the next cycle.
- Throughput: one access per cycle in total.
- Back-to-back requests from one port: with no contention, that port is granted every cycle.
- Read after write to the same address, from either port, in the following cycle returns the new data.
- Reset mid-INIT or mid-RUN:
  - Aborts immediately and init_cnt restarts from 0.
  - A pending rvalid/err is dropped (cleared by reset).
- Widths: init_cnt is $clog2(DEPTH)+1 bits so the terminal comparison does not wrap. mem_wdata during INIT is init_cnt zero-extended to DATA_W.

Decomposition:
- Shared package dmem_pkg holds:
  - Constants: DMEM_ADDR_W = 15, DMEM_DATA_W = 32, DMEM_DEPTH = 256.
  - Enum arb_state_t {INIT, RUN}.
  - Enum port_id_t {PORT_CPU = 0, PORT_DMA = 1}.
- One sub-module: rr_arb2. It is the combinational 2-way round-robin grant logic, with inputs req[1:0] and ptr, and output gnt[1:0] (one-hot or zero).
- The FSM, init counter, response registers and mux stay in dmem_arbiter.

Test Plan:
1. Fill sequence: reset for 2 cycles, then release.
   - init_done rises exactly 256 cycles later; gnt stays 0 throughout.
   - After init, reading addr 0x0005 returns 5 and reading 0x00FF returns 255.
2. Contention: after init, hold req0 = req1 = 1, both reads, for 4 cycles.
   - gnt pattern is 0,1,0,1, starting with port 0.
   - The rvalid pulses alternate accordingly, one cycle after each grant.
3. Write/read and write-port isolation:
   - Port 1 writes 0xDEADBEEF to 0x0010; port 0 reads 0x0010 the next cycle and gets rdata0 = 0xDEADBEEF.
   - A simultaneous port 0 write to 0x0011 is granted the cycle after the port 1 write.
4. Out of range: port 0 writes 0x12345678 to 0x0100, then reads 0x0100.
   - err0 pulses twice.
   - The read returns 0 with rvalid0 = 1.
   - Word 0x00FF is still 255 (no aliasing).
5. Reset mid-INIT: assert reset at fill cycle 100.
   - init_cnt restarts from 0 and init_done rises 256 cycles after reset release.
   - Reset during an outstanding read clears rvalid0 the following cycle.
6. INIT_EN = 0: after reset, a req0 read of 0x0003 is granted in the first cycle and rvalid0 follows on the next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 15;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 256;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: picks one requester, ptr breaks ties.
// Purely combinational, zero latency.
// A lone requester always wins; ptr matters only when both request.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    // Port 0 wins when alone or when the pointer favours it; port 1 likewise.
    always_comb begin
        o_gnt    = 2'b00;
        o_gnt[0] = i_req[0] & (~i_req[1] | ~i_ptr);
        o_gnt[1] = i_req[1] & (~i_req[0] |  i_ptr);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between CPU (port 0) and DMA (port 1), after a post-reset index fill.
// Grant is same-cycle; read data, rvalid and err appear one cycle after the grant.
// Requesters hold req until granted; nobody is granted while the fill runs.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              init_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra counter bit so the terminal value DEPTH-1 never wraps to 0.
    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  L_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W + 1)'(DEPTH);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_init_cnt;
    port_id_t          r_rr_ptr;
    logic              r_init_done;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_wdata;

    logic [1:0]        w_gnt_arb;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;
    logic              w_sel_oob;

    rr_arb2 u_rr_arb2 (
        .i_req (w_req_vec()),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt_arb)
    );

    function automatic logic [1:0] w_req_vec();
        return {req1, req0};
    endfunction

    // Route the winning port's request fields; port 1 only when it holds the grant.
    always_comb begin
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        w_sel_we    = we0;
        if (w_gnt_arb[1]) begin
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
            w_sel_we    = we1;
        end
        w_sel_oob = ({1'b0, w_sel_addr} >= L_DEPTH);
    end

    // Next state, grants and memory port drive; idle cycles keep addr/wdata stable.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        mem_we      = 1'b0;
        mem_addr    = r_hold_addr;
        mem_wdata   = r_hold_wdata;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else begin
            case (r_state)
                INIT: begin
                    mem_we    = 1'b1;
                    mem_addr  = ADDR_W'(r_init_cnt);
                    mem_wdata = DATA_W'(r_init_cnt);
                    if (r_init_cnt == L_LAST) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    w_gnt = w_gnt_arb;
                    if (|w_gnt_arb) begin
                        mem_addr  = w_sel_addr;
                        mem_wdata = w_sel_wdata;
                        mem_we    = w_sel_we & ~w_sel_oob;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // State register, fill counter and the sticky init_done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= (INIT_EN != 0) ? INIT : RUN;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if (w_state_nxt == RUN) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Round-robin pointer flips to the other port after every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= PORT_CPU;
        end else if (w_gnt[0]) begin
            r_rr_ptr <= PORT_DMA;
        end else if (w_gnt[1]) begin
            r_rr_ptr <= PORT_CPU;
        end
    end

    // Remember what the memory port last saw so idle cycles do not toggle it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else begin
            r_hold_addr  <= mem_addr;
            r_hold_wdata <= mem_wdata;
        end
    end

    // Per-port response: one-cycle rvalid/err pulses, read data held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt[0] & ~w_sel_we;
            r_rvalid1 <= w_gnt[1] & ~w_sel_we;
            r_err0    <= w_gnt[0] & w_sel_oob;
            r_err1    <= w_gnt[1] & w_sel_oob;
            if (w_gnt[0] && !w_sel_we) begin
                r_rdata0 <= w_sel_oob ? '0 : mem_rdata;
            end
            if (w_gnt[1] && !w_sel_we) begin
                r_rdata1 <= w_sel_oob ? '0 : mem_rdata;
            end
        end
    end

    assign gnt0      = w_gnt[0];
    assign gnt1      = w_gnt[1];
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: fill, contention, write/read, out-of-range, reset abort, no-init.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
// A second instance with INIT_EN = 0 covers the skip-fill configuration.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, init_done, mem_we;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;

    logic        rst_b = 1'b1;
    logic        req0b = 1'b0;
    logic [14:0] addr0b = '0;
    logic        gnt0b, gnt1b, rvalid0b, rvalid1b, err0b, err1b, init_done_b, mem_we_b;
    logic [31:0] rdata0b, rdata1b, mem_wdata_b, mem_rdata_b;
    logic [14:0] mem_addr_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    // Memory decodes only 8 address bits on writes, so a leaked out-of-range write would alias.
    always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata   = (mem_addr < 15'd256) ? ram[mem_addr[7:0]] : 32'hBAD0_BAD0;
    assign mem_rdata_b = 32'h0000_1000 + {17'b0, mem_addr_b};

    dmem_arbiter #(.INIT_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .init_done(init_done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.INIT_EN(0)) dut_b (
        .clk(clk), .reset(rst_b),
        .req0(req0b), .we0(1'b0), .addr0(addr0b), .wdata0(32'h0),
        .req1(1'b0), .we1(1'b0), .addr1(15'h0), .wdata1(32'h0),
        .gnt0(gnt0b), .gnt1(gnt1b), .rvalid0(rvalid0b), .rvalid1(rvalid1b),
        .rdata0(rdata0b), .rdata1(rdata1b), .err0(err0b), .err1(err1b),
        .init_done(init_done_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", gnt1, gnt0); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 15'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (rvalid0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0) begin errors++; $display("FAIL reset_resp: got %b %b %h want 0 0 0", rvalid0, err0, rdata0); end
    endtask

    task automatic test_fill();
        int done_at;
        logic gnt_seen;
        done_at  = -1;
        gnt_seen = 1'b0;
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (init_done) begin
                done_at = k;
                break;
            end
            if (gnt0 || gnt1) gnt_seen = 1'b1;
            if (k == 100) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd100 || mem_wdata !== 32'd100) begin errors++; $display("FAIL fill_cycle100: got we=%b a=%h d=%h want 1 64 64", mem_we, mem_addr, mem_wdata); end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (done_at !== 256) begin errors++; $display("FAIL fill_length: got %0d want 256", done_at); end
        checks++; if (gnt_seen !== 1'b0) begin errors++; $display("FAIL fill_gnt: got %b want 0", gnt_seen); end
        // Port 0 reads word 5, then port 1 reads word 255; leaves rr_ptr back on port 0.
        req0 = 1'b1; addr0 = 15'h0005;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 15'h0005) begin errors++; $display("FAIL fill_rd5_gnt: got %b%b a=%h want 01 0005", gnt1, gnt0, mem_addr); end
        tick();
        req0 = 1'b0;
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'd5) begin errors++; $display("FAIL fill_rd5: got %b %h want 1 5", rvalid0, rdata0); end
        req1 = 1'b1; addr1 = 15'h00FF;
        tick();
        req1 = 1'b0;
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'd255 || rvalid0 !== 1'b0) begin errors++; $display("FAIL fill_rd255: got %b %h rv0=%b want 1 ff 0", rvalid1, rdata1, rvalid0); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g0;
        exp_g0 = 4'b0101;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 15'h0020; addr1 = 15'h0030;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (gnt0 !== exp_g0[c] || gnt1 !== ~exp_g0[c]) begin errors++; $display("FAIL contention_gnt%0d: got %b%b want %b%b", c, gnt1, gnt0, ~exp_g0[c], exp_g0[c]); end
            tick();
            checks++; if (rvalid0 !== exp_g0[c] || rvalid1 !== ~exp_g0[c]) begin errors++; $display("FAIL contention_rv%0d: got %b%b want %b%b", c, rvalid1, rvalid0, ~exp_g0[c], exp_g0[c]); end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (rdata0 !== 32'h20 || rdata1 !== 32'h30) begin errors++; $display("FAIL contention_data: got %h %h want 20 30", rdata0, rdata1); end
    endtask

    task automatic test_write_read();
        // A port 0 read first moves rr_ptr to port 1.
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'h10) begin errors++; $display("FAIL wr_pre_read: got %h want 10", rdata0); end
        req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0010; wdata1 = 32'hDEAD_BEEF;
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0011; wdata0 = 32'hCAFE_F00D;
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'h0010 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_p1_first: got g=%b%b we=%b a=%h d=%h want 10 1 0010 deadbeef", gnt1, gnt0, mem_we, mem_addr, mem_wdata); end
        tick();
        req1 = 1'b0; we1 = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b1 || mem_addr !== 15'h0011 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_p0_second: got g0=%b a=%h we=%b want 1 0011 1", gnt0, mem_addr, mem_we); end
        tick();
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b%b want 00", rvalid1, rvalid0); end
        we0 = 1'b0; addr0 = 15'h0010;
        tick();
        req0 = 1'b0;
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_10: got %b %h want 1 deadbeef", rvalid0, rdata0); end
        // Write on port 1 immediately followed by a read on port 0.
        req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0012; wdata1 = 32'h1111_2222;
        tick();
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; addr0 = 15'h0012;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'h1111_2222) begin errors++; $display("FAIL raw_next_cycle: got %h want 11112222", rdata0); end
        req1 = 1'b1; addr1 = 15'h0011;
        tick();
        req1 = 1'b0;
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_rd_11: got %b %h want 1 cafef00d", rvalid1, rdata1); end
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'h0011) begin errors++; $display("FAIL idle_hold: got we=%b a=%h want 0 0011", mem_we, mem_addr); end
    endtask

    task automatic test_oob();
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0100; wdata0 = 32'h1234_5678;
        #1;
        checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL oob_wr_gate: got g0=%b we=%b want 1 0", gnt0, mem_we); end
        tick();
        checks++; if (err0 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL oob_wr_err: got err=%b rv=%b want 1 0", err0, rvalid0); end
        we0 = 1'b0;
        tick();
        req0 = 1'b0;
        checks++; if (err0 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin errors++; $display("FAIL oob_rd: got err=%b rv=%b d=%h want 1 1 0", err0, rvalid0, rdata0); end
        tick();
        checks++; if (err0 !== 1'b0 || rvalid0 !== 1'b0) begin errors++; $display("FAIL oob_pulse: got err=%b rv=%b want 0 0", err0, rvalid0); end
        req0 = 1'b1; addr0 = 15'h0000;
        tick();
        addr0 = 15'h00FF;
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL oob_alias0: got %h want 0", rdata0); end
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'd255 || err0 !== 1'b0) begin errors++; $display("FAIL oob_alias255: got %h err=%b want ff 0", rdata0, err0); end
    endtask

    task automatic test_reset_mid();
        int done_at;
        done_at = -1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0005;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt: got %b want 1", gnt0); end
        reset = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b0 || mem_addr !== 15'h0) begin errors++; $display("FAIL rst_gnt_forced: got g0=%b a=%h want 0 0", gnt0, mem_addr); end
        tick();
        req0 = 1'b0;
        checks++; if (rvalid0 !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL rst_rvalid_drop: got rv=%b done=%b want 0 0", rvalid0, init_done); end
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) tick();
        checks++; if (mem_addr !== 15'd100 || init_done !== 1'b0) begin errors++; $display("FAIL rst_mid_pos: got a=%h done=%b want 0064 0", mem_addr, init_done); end
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'h0) begin errors++; $display("FAIL rst_mid_bus: got we=%b a=%h want 0 0", mem_we, mem_addr); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (mem_addr !== 15'h0 || mem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_restart: got a=%h we=%b want 0000 1", mem_addr, mem_we); end
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (init_done) begin
                done_at = k;
                break;
            end
        end
        checks++; if (done_at !== 256) begin errors++; $display("FAIL rst_mid_length: got %0d want 256", done_at); end
    endtask

    task automatic test_no_init();
        rst_b = 1'b0;
        req0b = 1'b1; addr0b = 15'h0003;
        #1;
        checks++; if (gnt0b !== 1'b1 || mem_addr_b !== 15'h0003 || mem_we_b !== 1'b0) begin errors++; $display("FAIL noinit_gnt: got g=%b a=%h we=%b want 1 0003 0", gnt0b, mem_addr_b, mem_we_b); end
        tick();
        req0b = 1'b0;
        checks++; if (rvalid0b !== 1'b1 || rdata0b !== 32'h0000_1003) begin errors++; $display("FAIL noinit_rd: got %b %h want 1 00001003", rvalid0b, rdata0b); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_fill();
        test_contention();
        test_write_read();
        test_oob();
        test_reset_mid();
        test_no_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
